// File: rtl/branch_pred_pkg.sv
// branch_pred_pkg: shared constants and types for the branch direction predictor counter bank.
// Macro PRED_INIT_WEAK_TAKEN_EN selects a weakly-taken reset value instead of weakly-not-taken.
package branch_pred_pkg;
   localparam int NUM_ENTRIES = 1024;
   localparam int IDX_W       = $clog2(NUM_ENTRIES);
   localparam int IDX_LSB     = 2;
   localparam int CNT_W       = 2;
   localparam logic [CNT_W-1:0] SNT = 2'b00;
   localparam logic [CNT_W-1:0] WNT = 2'b01;
   localparam logic [CNT_W-1:0] WT  = 2'b10;
   localparam logic [CNT_W-1:0] ST  = 2'b11;
`ifdef PRED_INIT_WEAK_TAKEN_EN
   localparam logic [CNT_W-1:0] RST_VAL = WT;
`else
   localparam logic [CNT_W-1:0] RST_VAL = WNT;
`endif
   typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/sat_counter_2b.sv
// sat_counter_2b: one 2-bit saturating up/down direction counter.
// Ports: CLK clock; RESET async active-low reset to RST_VAL; en update strobe;
//        inc 1 = count up (taken), 0 = count down; pred_bit counter MSB.
module sat_counter_2b
   import branch_pred_pkg::*;
(
   input  logic CLK,
   input  logic RESET,
   input  logic en,
   input  logic inc,
   output logic pred_bit
);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) cnt <= RST_VAL;
      else if (en) cnt <= inc ? ((cnt == ST) ? ST : cnt + 1'b1) : ((cnt == SNT) ? SNT : cnt - 1'b1);
   assign pred_bit = cnt[CNT_W-1];
endmodule

// File: rtl/branch_pred_counter_bank.sv
// branch_pred_counter_bank: bank of NUM_ENTRIES 2-bit saturating counters indexed by InstrPC[11:2].
// Ports: CLK clock; RESET async active-low reset; isTaken resolved direction;
//        isBranch update qualifier; InstrPC ID-stage PC; Pred per-entry MSB (1 = taken).
// Macro PRED_INIT_WEAK_TAKEN_EN (see branch_pred_pkg) changes the reset value.
module branch_pred_counter_bank
   import branch_pred_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   isTaken,
   input  logic                   isBranch,
   input  logic [31:0]            InstrPC,
   output logic [NUM_ENTRIES-1:0] Pred
);
   idx_t idx;
   logic unused_pc;
   assign idx = InstrPC[IDX_LSB+IDX_W-1:IDX_LSB];
   // PC bits outside the index are deliberately ignored (no tag check).
   assign unused_pc = ^{InstrPC[31:IDX_LSB+IDX_W], InstrPC[IDX_LSB-1:0]};
   for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cnt
      sat_counter_2b u_cnt (
         .CLK      (CLK),
         .RESET    (RESET),
         .en       (isBranch && (idx == idx_t'(i))),
         .inc      (isTaken),
         .pred_bit (Pred[i])
      );
   end
endmodule

// File: tb/tb_branch_pred_counter_bank.sv
// tb_branch_pred_counter_bank: directed + model-checked bench for the predictor counter bank.
module tb_branch_pred_counter_bank;
   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          isTaken = 1'b0;
   logic          isBranch = 1'b0;
   logic [31:0]   InstrPC = 32'h0;
   logic [1023:0] Pred;
`ifdef PRED_INIT_WEAK_TAKEN_EN
   localparam int RV = 2;
`else
   localparam int RV = 1;
`endif
   int m [1024];
   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;
   logic [1023:0] base;
   logic [1023:0] mask;
   branch_pred_counter_bank dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .isTaken  (isTaken),
      .isBranch (isBranch),
      .InstrPC  (InstrPC),
      .Pred     (Pred)
   );
   always #5 CLK = ~CLK;
   function automatic logic [1023:0] exp_pred();
      logic [1023:0] e;
      for (int i = 0; i < 1024; i++) e[i] = (m[i] >= 2);
      return e;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 1024; i++) m[i] = RV;
   endtask
   task automatic chk(input string nm, input logic [1023:0] got, input logic [1023:0] want);
      int k;
      n_cmp++;
      if (got !== want) begin
         k = 0;
         for (int i = 1023; i >= 0; i--) if (got[i] !== want[i]) k = i;
         n_bad++;
         $display("FAIL %s: bit %0d is %b, required %b (%0d bits differ)", nm, k, got[k], want[k], $countones(got ^ want));
      end
   endtask
   task automatic step(input logic b, input logic t, input logic [31:0] pc);
      int k;
      isBranch = b;
      isTaken = t;
      InstrPC = pc;
      @(posedge CLK);
      if (b) begin
         k = int'(pc >> 2) % 1024;
         m[k] = t ? ((m[k] + 1 > 3) ? 3 : m[k] + 1) : ((m[k] - 1 < 0) ? 0 : m[k] - 1);
      end
      #1;
   endtask
   task automatic do_reset();
      isBranch = 1'b0;
      RESET = 1'b0;
      model_reset();
      @(posedge CLK);
      #1;
      @(negedge CLK);
      RESET = 1'b1;
   endtask
   always @(negedge CLK) if (checking) chk("model", Pred, exp_pred());
   initial begin
      base = (RV >= 2) ? {1024{1'b1}} : '0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("reset_state", Pred, base);
      checking = 1'b1;
      // train taken at index 4, then saturate
      step(1'b1, 1'b1, 32'h0000_0010);
      chk("taken_bit4", 1024'(Pred[4]), 1024'(1'b1));
      mask = '0;
      mask[4] = 1'b1;
      chk("taken_others", Pred & ~mask, base & ~mask);
      repeat (3) step(1'b1, 1'b1, 32'h0000_0010);
      step(1'b1, 1'b0, 32'h0000_0010);
      chk("taken_sat", 1024'(Pred[4]), 1024'(1'b1));
      // async reset mid-cycle, with an update presented while reset is held
      @(negedge CLK);
      #2;
      RESET = 1'b0;
      isBranch = 1'b1;
      isTaken = 1'b1;
      InstrPC = 32'h0000_0010;
      model_reset();
      #1;
      chk("async_reset", Pred, base);
      @(posedge CLK);
      #1;
      chk("reset_override", Pred, base);
      isBranch = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      // train not-taken at index 7, confirm floor at 00
      repeat (5) step(1'b1, 1'b0, 32'h0000_001C);
      chk("nt_bit7", 1024'(Pred[7]), 1024'(1'b0));
      step(1'b1, 1'b1, 32'h0000_001C);
      chk("nt_sat_1", 1024'(Pred[7]), 1024'(1'b0));
      step(1'b1, 1'b1, 32'h0000_001C);
      chk("nt_sat_2", 1024'(Pred[7]), 1024'(1'b1));
      // qualifier off
      do_reset();
      repeat (10) step(1'b0, 1'b1, 32'h0000_0010);
      chk("qual_off", Pred, base);
      // aliasing and ignored PC bits
      do_reset();
      step(1'b1, 1'b1, 32'h0000_1010);
      chk("alias_first", 1024'(Pred[4]), 1024'(1'b1));
      step(1'b1, 1'b1, 32'h0000_0013);
      step(1'b1, 1'b0, 32'hFFFF_F010);
      chk("alias_reached_st", 1024'(Pred[4]), 1024'(1'b1));
      chk("alias_1023", 1024'(Pred[1023]), 1024'(base[1023]));
      // boundary indices
      do_reset();
      step(1'b1, 1'b1, 32'h0000_0FFC);
      chk("bound_1023", 1024'(Pred[1023]), 1024'(1'b1));
      step(1'b1, 1'b1, 32'h0000_0000);
      chk("bound_0", 1024'(Pred[0]), 1024'(1'b1));
      mask = '0;
      mask[0] = 1'b1;
      mask[1023] = 1'b1;
      chk("bound_others", Pred & ~mask, base & ~mask);
      // mixed traffic over a few hot entries, checked by the model every cycle
      do_reset();
      for (int i = 0; i < 300; i++) begin
         int sel;
         case ($urandom_range(0, 4))
            0: sel = 0;
            1: sel = 4;
            2: sel = 7;
            3: sel = 513;
            default: sel = 1023;
         endcase
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom & 32'hFFFF_F003) | (32'(sel) << 2));
      end
      @(negedge CLK);
      #1;
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/branch_pred_counter_bank.md
Name: branch_pred_counter_bank

Overview:
- Bank of 2-bit saturating up/down counters forming the direction predictor behind the branch target buffer.
- Each counter tracks one PC slot selected by InstrPC[11:2]. The counter is trained when a resolved branch arrives from the ID stage.
- The MSB of every counter is exported in parallel on a flat prediction vector. The BTB indexes that vector with its own fetch and decode PCs.

Parameters:
- NUM_ENTRIES, 1024, number of counters; must be a power of two; index width IDX_W = log2(NUM_ENTRIES) = 10.
- IDX_LSB, 2, lowest PC bit used as index (word-aligned PCs); index = InstrPC[IDX_LSB+IDX_W-1 : IDX_LSB].
- CNT_W, 2, counter width; the prediction bit is counter[CNT_W-1].

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
- isTaken  input  1  resolved direction of the ID-stage branch; 1 = taken.
- isBranch  input  1  qualifier: the ID-stage instruction is a branch and its outcome is valid this cycle.
- InstrPC  input  32  PC of the ID-stage instruction; only bits [11:2] are used.
- Pred  output  NUM_ENTRIES  Pred[i] = MSB of counter i; 1 = predict taken.

Behaviour:
- Interface: one clock, CLK. Reset is asynchronous and active-low, named RESET.
- Reset: while RESET=0, every counter is forced immediately to 2'b01 (weakly not-taken), without waiting for a clock edge. Pred is therefore all zeros during and right after reset.
- Counter encoding:
  - 00 = strongly not-taken
  - 01 = weakly not-taken
  - 10 = weakly taken
  - 11 = strongly taken
- Update, on each rising CLK edge with RESET=1 and isBranch=1, for counter k = InstrPC[11:2]:
  - isTaken=1: k increments, saturating at 11.
  - isTaken=0: k decrements, saturating at 00.
  - Exactly one counter changes per cycle; all others hold.
- No update: when isBranch=0, all counters hold. isTaken and InstrPC are don't-care.
- Output timing: Pred is purely combinational from counter state. No output register and no input-to-output combinational path. An update at edge N is visible on Pred immediately after edge N; the next cycle's readers see it.
- Aliasing: PCs differing only outside bits [11:2] share a counter. This is accepted; there is no tag check.
- Bits [1:0] and [31:12] of InstrPC are ignored. Misaligned PCs index by bits [11:2] regardless.
- Reset mid-operation: asynchronous assertion overrides any in-flight update. The first update is taken at the first rising edge after RESET deasserts.
- Single write port: no simultaneous-update conflicts exist.

Optional Feature:
- Macro: PRED_INIT_WEAK_TAKEN_EN.
- Defined: reset value of every counter is 2'b10 (weakly taken). Pred reads all ones after reset, and a single not-taken update flips an entry to 0.
- Undefined (default): reset value is 2'b01 as specified above.
- No other behaviour changes.

Decomposition:
- Shared package branch_pred_pkg holds:
  - NUM_ENTRIES, IDX_W, IDX_LSB and CNT_W constants
  - the counter encoding constants (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11)
  - the reset-value constant, which selects on the macro
  - an index typedef (logic [IDX_W-1:0])
- One sub-module, sat_counter_2b:
  - Ports: CLK, RESET, en, inc; output pred_bit.
  - Instantiated NUM_ENTRIES times via generate.
  - Its en is driven by isBranch && (decoded index == i).

Test Plan:
- Reset: hold RESET=0, then release → Pred == 1024'b0 (all ones with PRED_INIT_WEAK_TAKEN_EN). Asserting RESET asynchronously mid-cycle clears a trained entry immediately, without a clock edge.
- Train taken: InstrPC=32'h0000_0010 (index 4), isBranch=1, isTaken=1 for 1 cycle → Pred[4]=1 and all other bits 0. 3 more taken cycles, then 1 not-taken → Pred[4] still 1, confirming saturation at 11.
- Train not-taken: from reset, index 7 (InstrPC=32'h1C), 5 not-taken cycles → Pred[7]=0. Then 1 taken → still 0; 2nd taken → Pred[7]=1, confirming saturation at 00.
- Qualifier off: isBranch=0, isTaken=1, InstrPC=32'h10 for 10 cycles → Pred unchanged, all 0.
- Aliasing and ignored bits: taken update at InstrPC=32'h0000_1010 and at 32'h0000_0013 → both hit index 4, so Pred[4]=1 after the first and the counter reaches 11 after the second. Pred[1023] is unaffected.
- Boundary index: InstrPC=32'h0000_0FFC taken once → Pred[1023]=1. InstrPC=32'h0000_0000 taken once → Pred[0]=1. No other bits set.
